mhd_stream_monitor: RTL and testbench

MHD_STREAM_MONITOR -- requirements
Module: mhd_stream_monitor

---
 rtl/mhd_pkg.sv | 21 ++
 rtl/mhd_popcount.sv | 19 +
 rtl/mhd_stream_monitor.sv | 130 +++++++++++++
 tb/tb_mhd_stream_monitor.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance stream monitor.
package mhd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mhd_state_e;

    // Smallest r with 2**r >= n; used to size distance and counter fields.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module mhd_popcount
    import mhd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned HDW = clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [HDW-1:0]   count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            count = count + HDW'(value[i]);
        end
    end

endmodule

// File: rtl/mhd_stream_monitor.sv
// Windowed Hamming-distance monitor: compares exact/approximate operand pairs through a
// two-stage pipeline and tracks violations and the worst distance over WIN pairs.
module mhd_stream_monitor
    import mhd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned WIN = 256,
    localparam int unsigned HDW = clog2(WIDTH + 1),
    localparam int unsigned CNTW = clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [HDW-1:0]   thr,
    input  logic [CNTW-1:0]  err_lim,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             hd_valid,
    output logic [HDW-1:0]   hd,
    output logic             viol,
    output logic [CNTW-1:0]  viol_cnt,
    output logic [HDW-1:0]   max_hd,
    output logic             done,
    output logic             fail
);

    mhd_state_e      state_q, state_d;
    logic [CNTW-1:0] acc_q;
    logic [HDW-1:0]  thr_q;
    logic [CNTW-1:0] err_lim_q;
    logic [WIDTH-1:0] s1_q;
    logic            s1_valid_q;
    logic [HDW-1:0]  hd_q;
    logic            s2_valid_q;
    logic [CNTW-1:0] viol_cnt_q;
    logic [HDW-1:0]  max_hd_q;
    logic            fail_q;
    logic [HDW-1:0]  pop_count;

    logic accept;
    logic start_ok;
    logic last_accept;

    assign in_ready    = (state_q == StRun);
    assign accept      = in_valid & in_ready;
    assign start_ok    = start & ~abort & ((state_q == StIdle) | (state_q == StDone));
    assign last_accept = accept & (acc_q == CNTW'(WIN - 1));

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (last_accept) state_d = StDrain;
                StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StDone;
                StDone:  if (start) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    mhd_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .value (s1_q),
        .count (pop_count)
    );

    // Abort flushes both stages so nothing in flight reaches the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            hd_q       <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept & ~abort;
            s2_valid_q <= s1_valid_q & ~abort;
            if (accept) s1_q <= a ^ b;
            if (s1_valid_q) hd_q <= pop_count;
        end
    end

    assign hd_valid = s2_valid_q;
    assign hd       = hd_q;
    assign viol     = s2_valid_q & (hd_q > thr_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            thr_q      <= '0;
            err_lim_q  <= '0;
            viol_cnt_q <= '0;
            max_hd_q   <= '0;
            fail_q     <= 1'b0;
        end else if (start_ok) begin
            acc_q      <= '0;
            thr_q      <= thr;
            err_lim_q  <= err_lim;
            viol_cnt_q <= '0;
            max_hd_q   <= '0;
            fail_q     <= 1'b0;
        end else begin
            if (accept) acc_q <= acc_q + CNTW'(1);
            if (viol && (viol_cnt_q != '1)) viol_cnt_q <= viol_cnt_q + CNTW'(1);
            if (hd_valid && (hd_q > max_hd_q)) max_hd_q <= hd_q;
            // Pipeline is empty on this edge, so the count is final.
            if ((state_q == StDrain) && (state_d == StDone)) fail_q <= viol_cnt_q > err_lim_q;
        end
    end

    assign viol_cnt = viol_cnt_q;
    assign max_hd   = max_hd_q;
    assign done     = (state_q == StDone);
    assign fail     = fail_q & done;

endmodule

// File: tb/tb_mhd_stream_monitor.sv
// Directed bench: WIN=4 instance for window/latency/abort checks, WIN=8 instance for reset.
module tb_mhd_stream_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, in_valid;
    logic [3:0] thr;
    logic [2:0] err_lim;
    logic [3:0] err_lim8;
    logic [7:0] a, b;

    logic       in_ready, hd_valid, viol, done, fail;
    logic [3:0] hd, max_hd;
    logic [2:0] viol_cnt;

    logic       in_ready8, hd_valid8, viol8, done8, fail8;
    logic [3:0] hd8, max_hd8, viol_cnt8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mhd_stream_monitor #(.WIDTH(8), .WIN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .thr(thr), .err_lim(err_lim),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .hd_valid(hd_valid),
        .hd(hd), .viol(viol), .viol_cnt(viol_cnt), .max_hd(max_hd), .done(done), .fail(fail)
    );

    mhd_stream_monitor #(.WIDTH(8), .WIN(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .thr(thr), .err_lim(err_lim8),
        .in_valid(in_valid), .in_ready(in_ready8), .a(a), .b(b), .hd_valid(hd_valid8),
        .hd(hd8), .viol(viol8), .viol_cnt(viol_cnt8), .max_hd(max_hd8), .done(done8),
        .fail(fail8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIN=4 window on dut: a=00, b bytes from bv (byte 0 first).
    task automatic window(input logic [3:0] t, input logic [2:0] lim, input logic [31:0] bv,
                          input logic [15:0] hdv, input logic [3:0] vv,
                          input logic [2:0] cnt_exp, input logic [3:0] max_exp,
                          input logic fail_exp);
        thr = t;
        err_lim = lim;
        err_lim8 = {1'b0, lim};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("win_ready", in_ready, 1);
        chk("win_cnt0", viol_cnt, 0);
        chk("win_max0", max_hd, 0);
        chk("win_done0", done, 0);
        for (int k = 0; k < 7; k++) begin
            a = 8'h00;
            in_valid = (k < 4);
            if (k < 4) b = bv[8*k +: 8];
            tick();
            if (k == 0) chk("lat_n1", hd_valid, 0);
            if (k >= 1 && k <= 4) begin
                chk("hd_valid", hd_valid, 1);
                chk("hd", hd, hdv[4*(k-1) +: 4]);
                chk("viol", viol, vv[k-1]);
            end
            if (k == 3) chk("ready_drop", in_ready, 0);
            if (k == 5) begin
                chk("hd_valid_end", hd_valid, 0);
                chk("done_early", done, 0);
            end
            if (k == 6) chk("done", done, 1);
        end
        chk("viol_cnt", viol_cnt, cnt_exp);
        chk("max_hd", max_hd, max_exp);
        chk("fail", fail, fail_exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        thr = '0; err_lim = '0; err_lim8 = '0; a = '0; b = '0;
        tick();
        tick();
        chk("rst_ready", in_ready, 0);
        chk("rst_hdv", hd_valid, 0);
        chk("rst_viol", viol, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", fail, 0);
        chk("rst_cnt", viol_cnt, 0);
        chk("rst_max", max_hd, 0);
        rst = 1'b0;
        tick();

        // hd 8,4,5,0 against thr 4
        window(4'd4, 3'd1, 32'h001F0FFF, 16'h0548, 4'b0101, 3'd2, 4'd8, 1'b1);
        window(4'd4, 3'd2, 32'h001F0FFF, 16'h0548, 4'b0101, 3'd2, 4'd8, 1'b0);
        // thr = WIDTH: never a violation
        window(4'd8, 3'd0, 32'hFFFFFFFF, 16'h8888, 4'b0000, 3'd0, 4'd8, 1'b0);
        // thr = 0: any nonzero difference violates
        window(4'd0, 3'd2, 32'h03800001, 16'h2101, 4'b1101, 3'd3, 4'd2, 1'b1);

        // Abort one cycle after an accept
        thr = 4'd4; err_lim = 3'd1; err_lim8 = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; b = 8'hFF;
        tick();
        in_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_hdv", hd_valid, 0);
        chk("abort_idle", in_ready, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_hdv2", hd_valid, 0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_wins", in_ready, 0);

        // Reset mid-window on the WIN=8 instance at accept 3
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("w8_ready", in_ready8, 1);
        in_valid = 1'b1; b = 8'hFF;
        for (int k = 0; k < 3; k++) tick();
        chk("w8_pre_cnt", viol_cnt8, 1);
        chk("w8_pre_max", max_hd8, 8);
        chk("w8_pre_hdv", hd_valid8, 1);
        rst = 1'b1;
        #1;
        chk("w8_rst_ready", in_ready8, 0);
        chk("w8_rst_hdv", hd_valid8, 0);
        chk("w8_rst_hd", hd8, 0);
        chk("w8_rst_viol", viol8, 0);
        chk("w8_rst_cnt", viol_cnt8, 0);
        chk("w8_rst_max", max_hd8, 0);
        chk("w8_rst_done", done8, 0);
        chk("w8_rst_fail", fail8, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("w8_quiet_hdv", hd_valid8, 0);
        end

        // Fresh window after reset: hd 2 each, under thr 4
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("w8_new_cnt", viol_cnt8, 0);
        chk("w8_new_max", max_hd8, 0);
        in_valid = 1'b1; b = 8'h03;
        for (int k = 0; k < 8; k++) tick();
        in_valid = 1'b0;
        chk("w8_ready_drop", in_ready8, 0);
        for (int k = 0; k < 10 && !done8; k++) tick();
        chk("w8_done", done8, 1);
        chk("w8_cnt", viol_cnt8, 0);
        chk("w8_max", max_hd8, 2);
        chk("w8_fail", fail8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
